cacheline_adaptor: RTL
======================

# cacheline_adaptor

Responder for the cache's physical-memory port: accepts whole-line read/write requests from the cache controller and serialises them into fixed-length bursts on the external burst-memory interface. It sits between the cache (pmem_read/pmem_write/pmem_resp side) and main memory. A read assembles a full line from burst beats before responding; a write slices the line into beats.

## Interface
- LINE_W, 256, cache line width in bits
- BEAT_W, 64, burst beat width; BEATS = LINE_W/BEAT_W (4)
- ADDR_W, 32, address width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- address_i  in  ADDR_W  line address from cache
- read_i  in  1  line read request, held until resp_o
- write_i  in  1  line write request, held until resp_o
- line_i  in  LINE_W  write data, stable while write_i high
- line_o  out  LINE_W  read data, valid when resp_o high
- resp_o  out  1  one-cycle completion pulse
- address_o  out  ADDR_W  burst address to memory
- read_o  out  1  burst read request
- write_o  out  1  burst write request
- burst_o  out  BEAT_W  write beat data
- burst_i  in  BEAT_W  read beat data
- resp_i  in  1  memory beat handshake; one beat per high cycle

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: write_i high -> WRITE; else read_i high -> READ (write wins if both). Capture address_i into address register; clear beat counter.
- READ: read_o=1. Each cycle with resp_i=1: line register slice [BEAT_W*cnt +: BEAT_W] <= burst_i, cnt++. On beat BEATS-1 -> DONE. Cycles with resp_i=0 are gaps: hold.
- WRITE: write_o=1, burst_o = line_i[BEAT_W*cnt +: BEAT_W]. Each resp_i=1 consumes a beat, cnt++. On beat BEATS-1 -> DONE.
- DONE: resp_o=1 for exactly one cycle -> IDLE. read_o/write_o low.
- line_o driven from line register; holds last completed read until the next read's first beat overwrites it. Not cleared by writes.
- resp_i outside READ/WRITE ignored. Counter width clog2(BEATS); wraps to 0 on final beat.
- Reset: state IDLE, cnt 0, line register 0, address register 0; resp_o, read_o, write_o low, burst_o 0. Reset mid-burst discards partial line; read_o/write_o low the cycle after rst sampled.

## Timing
- Request seen in IDLE at cycle 0; read_o/write_o high from cycle 1.
- With resp_i high cycles 1-4, resp_o high cycle 5, IDLE cycle 6. Minimum request-to-resp latency 5 cycles; each resp_i gap adds one.
- read_o/write_o, address_o, burst_o are combinational from state/registers; address_o stable for the whole burst.
- Cache drops its request the cycle after resp_o; IDLE in cycle 6 sees it low, so no duplicate request. Request re-asserted in cycle 6 starts a new transaction.

## Configuration
- CACHELINE_ADAPTOR_ALIGN_EN defined: address_o low clog2(LINE_W/8) bits forced to 0 (line-aligned burst).
- Undefined: address_o equals captured address_i unmodified.

## Structure
- Shared package cacheline_pkg: state enum type, LINE_W/BEAT_W/BEATS constants, beat-index typedef.
- No sub-module; single module with state register, beat counter, line register, address register.

## Test plan
- Reset then read of 0x0000_1000 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> read_o cycles 1-4, resp_o cycle 5 only, line_o = {0x44..44,0x33..33,0x22..22,0x11..11}.
- Write line {D3,D2,D1,D0} with resp_i having 2-cycle gaps -> burst_o presents D0,D1,D2,D3 in order, each held until its resp_i, resp_o one cycle after last beat.
- read_i and write_i both high in IDLE -> write_o asserted, read_o never asserted, line_o unchanged.
- rst asserted after 2 read beats -> next cycle read_o=0, resp_o never pulses; subsequent full read returns correct line.
- Address 0x0000_101C with CACHELINE_ADAPTOR_ALIGN_EN -> address_o 0x0000_1000; without -> 0x0000_101C.
- Stray resp_i pulses in IDLE -> no state change, no resp_o, line_o unchanged.

Source files
------------

// File: rtl/cacheline_pkg.sv
// Shared types and constants for the cache-line to burst-memory adaptor.
// Holds the line/beat geometry, the controller state encoding and the
// beat-index type used by the serialiser.
package cacheline_pkg;

    // Line and beat geometry
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);

    // Bytes per line, used to build the alignment mask for burst addresses
    localparam int LINE_BYTES = LINE_W / 8;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index of the beat currently being transferred within a line
    typedef logic [CNT_W-1:0] beat_idx_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cache-line to burst-memory adaptor.
// Accepts whole-line read/write requests from the cache and turns each into
// a fixed-length burst of BEATS beats on the memory side. Reads assemble the
// line beat by beat and respond once it is complete; writes slice the line.
// Optional build macro: CACHELINE_ADAPTOR_ALIGN_EN forces the burst address
// to be line aligned (low offset bits cleared).
module cacheline_adaptor
    import cacheline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    // Cache side
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    output logic              resp_o,

    // Burst memory side
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [BEAT_W-1:0] burst_o,
    input  logic [BEAT_W-1:0] burst_i,
    input  logic              resp_i
);

    state_t            r_state;
    state_t            w_nextState;
    beat_idx_t         r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_line;
    logic              w_lastBeat;

    // The final beat is the one taken while the counter sits at BEATS-1
    assign w_lastBeat = (r_cnt == beat_idx_t'(BEATS - 1));

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Datapath: capture the request address, count beats and assemble read lines
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_line <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (write_i || read_i) begin
                        r_addr <= address_i;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        r_line[BEAT_W*r_cnt +: BEAT_W] <= burst_i;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and burst-side outputs; write requests win over reads
    always_comb begin
        w_nextState = r_state;
        read_o      = 1'b0;
        write_o     = 1'b0;
        resp_o      = 1'b0;
        burst_o     = '0;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_nextState = WRITE;
                end else if (read_i) begin
                    w_nextState = READ;
                end
            end
            READ: begin
                read_o = 1'b1;
                if (resp_i && w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            WRITE: begin
                write_o = 1'b1;
                burst_o = line_i[BEAT_W*r_cnt +: BEAT_W];
                if (resp_i && w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                resp_o      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Read data always reflects the line register, so it survives writes
    assign line_o = r_line;

    // Burst address, optionally forced onto a line boundary
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    assign address_o = r_addr & ~ADDR_W'(LINE_BYTES - 1);
`else
    assign address_o = r_addr;
`endif

endmodule
